column_cfg_loader: RTL and testbench
====================================

Name: column_cfg_loader

Overview:
- Parametrised configuration loader for one fabric column of NUM_TILES tiles.
- Accepts configuration words over a valid/ready stream and serialises them into the column's CLB scan chain or connection scan chain. Chain length is NUM_TILES × bits-per-tile.
- Verify mode recirculates a chain non-destructively and counts mismatches against expected words.
- Sits between the host configuration interface and the column's clb_scan_*/conn_scan_* pins.

Parameters:
NUM_TILES, 8, tiles in the column (≥1)
CLB_BITS, 18, CLB chain bits per tile
CONN_BITS, 72, connection chain bits per tile
WORD_W, 8, configuration word width
CNT_W, derived $clog2(NUM_TILES*max(CLB_BITS,CONN_BITS)+1), mismatch counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; honoured only in IDLE
mode  in  1  0=LOAD, 1=VERIFY; latched at start
chain_sel  in  1  0=CLB chain, 1=CONN chain; latched at start
word_data  in  WORD_W  configuration/expected word, LSB shifted first
word_valid  in  1  word_data valid
word_ready  out  1  loader accepts word this cycle
busy  out  1  high from cycle after start until DONE exits
done  out  1  one-cycle pulse at completion
mismatch_cnt  out  CNT_W  VERIFY mismatches, saturating; cleared at start
scan_clk  out  1  generated shift clock to column
clb_scan_en  out  1  CLB chain shift enable
clb_scan_in  out  1  serial data to CLB chain head
clb_scan_out  in  1  serial data from CLB chain tail
conn_scan_en  out  1  connection chain shift enable
conn_scan_in  out  1  serial data to conn chain head
conn_scan_out  in  1  serial data from conn chain tail

Behaviour:
- Single clock domain: clk. Reset: rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; counters 0.
- Chain length: LEN = NUM_TILES × (chain_sel ? CONN_BITS : CLB_BITS).
- Word count: NW = ceil(LEN / WORD_W). Bits above LEN in the final word are ignored, and no shift is generated for them.
- FSM states: IDLE, FETCH, SH_LO, SH_HI, DONE.
- IDLE:
  - start=1 latches mode and chain_sel, clears mismatch_cnt, clears the bit counter, then moves to FETCH.
  - start is ignored in every other state.
- FETCH:
  - word_ready=1.
  - On valid&&ready, capture the word into the shift register and move to SH_LO.
  - A stalled source holds FETCH indefinitely; scan_clk stays 0 and the chain does not move.
- SH_LO (one clk):
  - scan_clk=0.
  - Head data driven = LOAD ? current word bit : tail input of the selected chain (recirculation).
  - In VERIFY, the tail bit is compared to the current word bit. On inequality, mismatch_cnt increments, saturating at all-ones.
- SH_HI (one clk):
  - scan_clk=1, so the fabric shifts on the scan_clk rising edge.
  - Head data is held stable.
  - Bit counter and word bit index then advance:
    - bit counter == LEN-1 → DONE;
    - else word bit index == WORD_W-1 → FETCH;
    - else → SH_LO.
- DONE (one clk): done=1, busy=1, then return to IDLE.
- Scan enables:
  - Only the selected chain's scan_en is high, from FETCH entry through the last SH_HI.
  - It is low in DONE and IDLE.
  - The non-selected chain's scan_in and scan_en are held at 0.
- Glitch-free outputs: scan_clk and all scan_in/scan_en outputs are registered.
- Throughput and latency:
  - 2 clk per bit, plus ≥1 FETCH clk per word.
  - Minimum start→done is 1 + NW + 2·LEN cycles.
- LOAD: bits leaving the tail are discarded.
- Bit ordering: the first bit shifted lands at the tail end (last tile, highest bit) after LEN shifts.
- Reset mid-operation: everything returns to reset values immediately. Chain contents are then undefined, and the host must reload.

Decomposition:
- Shared package cfg_pkg holds:
  - mode_t (LOAD, VERIFY), chain_t (CLB, CONN), state_t;
  - function chain_len(num_tiles, bits_per_tile);
  - function word_count(len, word_w).
- Sub-module scan_bit_serializer holds:
  - the WORD_W shift register, bit index, two-phase scan_clk generation and head-data mux;
  - an interface of load strobe, word, recirculate select, tail input, head output, scan_clk, and bit_last/word_last flags.
- The top level holds the FSM, the bit counter, the mismatch counter and the chain demux.

Test Plan:
- All tests use NUM_TILES=2, CLB_BITS=18, CONN_BITS=72, WORD_W=8, a behavioural shift-register model of each chain, and source always valid.
- LOAD CLB, words 0xA5,0x3C,0xFF,0x00,0x0B:
  - exactly 36 scan_clk rising edges;
  - model holds those bits LSB-first, final word bits 7:4 unused;
  - done at cycle 1+5+72=78;
  - conn_scan_en stays 0.
- VERIFY CLB after the above load with the same words:
  - mismatch_cnt=0;
  - chain contents unchanged.
  - Repeat with word0=0xA4 → mismatch_cnt=1.
- LOAD CONN, 144 bits with word_valid deasserted for 10 cycles before word 5:
  - scan_clk stays 0 during the stall;
  - conn_scan_en held 1;
  - final contents correct;
  - done at cycle 1+18+288+10.
- start pulses while busy, plus start again in the DONE cycle:
  - both ignored;
  - exactly one done pulse;
  - mode/chain_sel changes mid-operation have no effect.
- rst_n asserted during SH_HI of bit 20:
  - all outputs 0 asynchronously;
  - after release, a fresh LOAD completes correctly.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the column configuration loader.
// Chain length and word count are derived from tile count and per-tile chain width.
package cfg_pkg;

  typedef enum logic {LOAD = 1'b0, VERIFY = 1'b1} mode_t;
  typedef enum logic {CLB = 1'b0, CONN = 1'b1} chain_t;
  typedef enum logic [2:0] {IDLE, FETCH, SH_LO, SH_HI, DONE} state_t;

  function automatic int unsigned chain_len(input int unsigned num_tiles,
                                            input int unsigned bits_per_tile);
    return num_tiles * bits_per_tile;
  endfunction

  function automatic int unsigned word_count(input int unsigned len,
                                             input int unsigned word_w);
    return (len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/scan_bit_serializer.sv
// Word shift register and two-phase scan clock; one bit per SH_LO/SH_HI pair.
// Head data is presented combinationally so the top can register it before the rising scan_clk.
module scan_bit_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              advance,
  input  logic              recirc,
  input  logic              tail,
  input  logic              clk_hi,
  output logic              head,
  output logic              cur_bit,
  output logic              scan_clk,
  output logic              word_last
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_sh;
  logic [IDX_W-1:0]  bit_idx;

  assign shreg_sh  = shreg >> 1;
  assign cur_bit   = shreg[0];
  assign word_last = (bit_idx == IDX_W'(WORD_W - 1));

  // Bit that the head will carry in the next SH_LO: a fresh word's LSB, or the following bit.
  always_comb begin
    head = 1'b0;
    if (recirc) head = tail;
    else if (load) head = word[0];
    else head = shreg_sh[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_idx  <= '0;
      scan_clk <= 1'b0;
    end else begin
      scan_clk <= clk_hi;
      if (load) begin
        shreg   <= word;
        bit_idx <= '0;
      end else if (advance) begin
        shreg   <= shreg_sh;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/column_cfg_loader.sv
// Loads or verifies one column's CLB/connection scan chain from a valid/ready word stream.
// Two clk per bit plus one FETCH per word; a stalled source parks the FSM in FETCH with scan_clk low.
module column_cfg_loader
  import cfg_pkg::*;
#(
  parameter int NUM_TILES = 8,
  parameter int CLB_BITS  = 18,
  parameter int CONN_BITS = 72,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(NUM_TILES * ((CLB_BITS > CONN_BITS) ? CLB_BITS : CONN_BITS) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              chain_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              scan_clk,
  output logic              clb_scan_en,
  output logic              clb_scan_in,
  input  logic              clb_scan_out,
  output logic              conn_scan_en,
  output logic              conn_scan_in,
  input  logic              conn_scan_out
);

  localparam int unsigned CLB_LEN  = chain_len(NUM_TILES, CLB_BITS);
  localparam int unsigned CONN_LEN = chain_len(NUM_TILES, CONN_BITS);

  state_t           state, state_nxt;
  mode_t            mode_q;
  chain_t           chain_q, chain_nxt;
  logic [CNT_W-1:0] bit_cnt, last_bit;
  logic             load, advance, tail_bit, head_bit, cur_bit, word_last;
  logic             shifting_nxt;

  assign last_bit     = (chain_q == CONN) ? CNT_W'(CONN_LEN - 1) : CNT_W'(CLB_LEN - 1);
  assign tail_bit     = (chain_q == CONN) ? conn_scan_out : clb_scan_out;
  assign chain_nxt    = (state == IDLE && start) ? chain_t'(chain_sel) : chain_q;
  assign shifting_nxt = state_nxt inside {FETCH, SH_LO, SH_HI};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (word_valid) state_nxt = SH_LO;
      SH_LO:   state_nxt = SH_HI;
      SH_HI: begin
        if (bit_cnt == last_bit) state_nxt = DONE;
        else if (word_last)      state_nxt = FETCH;
        else                     state_nxt = SH_LO;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word_ready = (state == FETCH);
    busy       = (state != IDLE);
    done       = (state == DONE);
    load       = (state == FETCH) && word_valid;
    advance    = (state == SH_HI);
  end

  scan_bit_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .word      (word_data),
    .advance   (advance),
    .recirc    (mode_q == VERIFY),
    .tail      (tail_bit),
    .clk_hi    (state_nxt == SH_HI),
    .head      (head_bit),
    .cur_bit   (cur_bit),
    .scan_clk  (scan_clk),
    .word_last (word_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= LOAD;
      chain_q      <= CLB;
      bit_cnt      <= '0;
      mismatch_cnt <= '0;
      clb_scan_en  <= 1'b0;
      conn_scan_en <= 1'b0;
      clb_scan_in  <= 1'b0;
      conn_scan_in <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q       <= mode_t'(mode);
        chain_q      <= chain_t'(chain_sel);
        bit_cnt      <= '0;
        mismatch_cnt <= '0;
      end
      if (state == SH_HI) bit_cnt <= bit_cnt + 1'b1;
      if (state == SH_LO && mode_q == VERIFY && tail_bit != cur_bit && mismatch_cnt != '1)
        mismatch_cnt <= mismatch_cnt + 1'b1;
      clb_scan_en  <= shifting_nxt && (chain_nxt == CLB);
      conn_scan_en <= shifting_nxt && (chain_nxt == CONN);
      // Head is set up on entry to SH_LO and held through SH_HI so it is stable at the rising scan_clk.
      if (state_nxt == SH_LO) begin
        clb_scan_in  <= (chain_q == CLB) && head_bit;
        conn_scan_in <= (chain_q == CONN) && head_bit;
      end else if (state_nxt != SH_HI) begin
        clb_scan_in  <= 1'b0;
        conn_scan_in <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_column_cfg_loader.sv
// Scoreboarded bench for column_cfg_loader with behavioural models of both scan chains.
module tb_column_cfg_loader;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, chain_sel = 1'b0;
  logic       word_valid = 1'b0;
  logic [7:0] word_data = 8'h00;
  logic       word_ready, busy, done, scan_clk;
  logic       clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in;
  logic       clb_scan_out, conn_scan_out;
  logic [7:0] mismatch_cnt;

  logic [35:0]  clb_ch  = '0;
  logic [143:0] conn_ch = '0;
  logic [7:0]   wbuf [18];
  int cyc = 0, edge_total = 0;
  int checks = 0, errors = 0;

  typedef struct {
    int           lat;
    int           mm;
    int           edges;
    logic         ch;
    logic [143:0] img;
  } exp_t;
  exp_t sbq[$];

  column_cfg_loader #(.NUM_TILES(2), .CLB_BITS(18), .CONN_BITS(72), .WORD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .chain_sel(chain_sel),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .scan_clk(scan_clk),
    .clb_scan_en(clb_scan_en), .clb_scan_in(clb_scan_in), .clb_scan_out(clb_scan_out),
    .conn_scan_en(conn_scan_en), .conn_scan_in(conn_scan_in), .conn_scan_out(conn_scan_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fabric chains: head at bit 0, tail at the MSB, shifting on the rising scan_clk when enabled.
  assign clb_scan_out  = clb_ch[35];
  assign conn_scan_out = conn_ch[143];
  always @(posedge scan_clk) begin
    edge_total <= edge_total + 1;
    if (clb_scan_en)  clb_ch  <= {clb_ch[34:0], clb_scan_in};
    if (conn_scan_en) conn_ch <= {conn_ch[142:0], conn_scan_in};
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_img(input string name, input logic [143:0] act, input logic [143:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [143:0] build_img(input int len);
    logic [143:0] v = '0;
    for (int k = 0; k < len; k++) v[len-1-k] = wbuf[k/8][k%8];
    return v;
  endfunction

  function automatic int outs_word();
    return int'({word_ready, busy, done, mismatch_cnt, scan_clk,
                 clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in});
  endfunction

  // Monitor: a transaction begins when busy rises (the cycle after start) and ends on done.
  int   t_start = 0, e_base = 0;
  logic busy_prev = 1'b0, seen_clb = 1'b0, seen_conn = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busy && !busy_prev) begin
      t_start   = cyc - 1;
      e_base    = edge_total;
      seen_clb  = 1'b0;
      seen_conn = 1'b0;
    end
    busy_prev = busy;
    if (clb_scan_en)  seen_clb  = 1'b1;
    if (conn_scan_en) seen_conn = 1'b1;
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done pulse at cycle %0d with nothing expected", cyc);
      end else begin
        e = sbq.pop_front();
        chk("latency", cyc - t_start, e.lat);
        chk("mismatch_cnt", int'(mismatch_cnt), e.mm);
        chk("scan_edges", edge_total - e_base, e.edges);
        chk("en_low_in_done", int'({clb_scan_en, conn_scan_en}), 0);
        if (e.ch) begin
          chk_img("conn_image", conn_ch, e.img);
          chk("clb_en_unused", int'(seen_clb), 0);
        end else begin
          chk_img("clb_image", {108'b0, clb_ch}, e.img);
          chk("conn_en_unused", int'(seen_conn), 0);
        end
      end
    end
  end

  task automatic push_exp(input int lat, input int mm, input int edges, input logic ch,
                          input logic [143:0] img);
    exp_t e;
    e.lat = lat; e.mm = mm; e.edges = edges; e.ch = ch; e.img = img;
    sbq.push_back(e);
  endtask

  task automatic set5(input logic [7:0] a, b, c, d, f);
    wbuf[0] = a; wbuf[1] = b; wbuf[2] = c; wbuf[3] = d; wbuf[4] = f;
  endtask

  task automatic issue_start(input logic m, input logic c);
    @(negedge clk);
    mode = m; chain_sel = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Source is valid except for stall_len FETCH cycles in front of word stall_idx.
  task automatic feed(input int nw, input int stall_idx, input int stall_len, input logic ch);
    int i = 0, sc = 0, guard = 0;
    while (i < nw && rst_n && guard < 2000) begin
      if (word_ready && i == stall_idx && sc < stall_len) begin
        word_valid = 1'b0;
        sc++;
        chk("stall_scan_clk", int'(scan_clk), 0);
        chk("stall_scan_en", int'(ch ? conn_scan_en : clb_scan_en), 1);
      end else begin
        word_valid = 1'b1;
        word_data  = wbuf[i];
        if (word_ready) i++;
      end
      @(negedge clk);
      guard++;
    end
    word_valid = 1'b0;
    if (guard >= 2000) chk("feed_words_taken", i, nw);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic disturb();
    int k = 0;
    while (k < 400) begin
      @(negedge clk);
      if (done || !busy) break;
      start = (k % 5 == 2); mode = k[0]; chain_sel = k[1];
      k++;
    end
    start = 1'b0; mode = 1'b0; chain_sel = 1'b0;
  endtask

  task automatic reset_at_bit20();
    int base = edge_total;
    int n = 0;
    while (!(scan_clk && (edge_total - base) == 21) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit20_hi", edge_total - base, 21);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", outs_word(), 0);
    repeat (2) @(negedge clk);
    chk("held_reset_outputs", outs_word(), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_word(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);

    // LOAD CLB: 36 bits, last word's upper nibble unused
    set5(8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h0B);
    push_exp(78, 0, 36, 1'b0, {108'b0, 36'hA53CFF00D});
    issue_start(1'b0, 1'b0);
    feed(5, -1, 0, 1'b0);
    wait_done(400);
    @(negedge clk);

    // VERIFY with matching words, then with one flipped bit
    push_exp(78, 0, 36, 1'b0, {108'b0, 36'hA53CFF00D});
    issue_start(1'b1, 1'b0);
    feed(5, -1, 0, 1'b0);
    wait_done(400);
    @(negedge clk);
    wbuf[0] = 8'hA4;
    push_exp(78, 1, 36, 1'b0, {108'b0, 36'hA53CFF00D});
    issue_start(1'b1, 1'b0);
    feed(5, -1, 0, 1'b0);
    wait_done(400);
    @(negedge clk);

    // LOAD CONN: 144 bits, 10-cycle source stall before word 5
    wbuf = '{8'h01, 8'h80, 8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'hE7,
             8'h18, 8'h9C, 8'h63, 8'hDE, 8'h21, 8'hB4, 8'h4B, 8'h7E, 8'h81};
    push_exp(317, 0, 144, 1'b1, build_img(144));
    issue_start(1'b0, 1'b1);
    feed(18, 5, 10, 1'b1);
    wait_done(1000);
    chk("conn_first_word_at_tail", int'(conn_ch[143:136]), 'h80);
    chk_img("clb_untouched", {108'b0, clb_ch}, {108'b0, 36'hA53CFF00D});
    @(negedge clk);

    // start/mode/chain_sel wiggled while busy and start raised in the DONE cycle
    set5(8'h5A, 8'hC3, 8'h00, 8'hFF, 8'h04);
    push_exp(78, 0, 36, 1'b0, build_img(36));
    issue_start(1'b0, 1'b0);
    fork
      feed(5, -1, 0, 1'b0);
      disturb();
    join
    wait_done(400);
    start = 1'b1; mode = 1'b1; chain_sel = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 1'b0; chain_sel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_done_start", int'(busy), 0);
    end

    // Reset during SH_HI of bit 20, then a fresh load
    set5(8'h12, 8'h34, 8'h56, 8'h78, 8'h09);
    issue_start(1'b0, 1'b0);
    fork
      feed(5, -1, 0, 1'b0);
      reset_at_bit20();
    join
    @(negedge clk);
    set5(8'h96, 8'hE1, 8'h7F, 8'h80, 8'h03);
    push_exp(78, 0, 36, 1'b0, build_img(36));
    issue_start(1'b0, 1'b0);
    feed(5, -1, 0, 1'b0);
    wait_done(400);
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
